// File: rtl/rf_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// rf_writeback_arbiter
//
// Drives the single write port of the integer register file. It merges two
// writeback sources:
//   - the in-order pipeline writeback, which always wins and is never stalled;
//   - a long-latency unit (divider / FPU integer results), which is accepted
//     through a valid/ready handshake into a small FIFO and drains into the
//     register file on cycles the pipeline leaves free.
// It also keeps a 32-entry busy scoreboard of registers still owed by the
// long-latency unit, and gives decode a hazard stall.
//
// Handshake (lu_valid / lu_ready): a result transfers on every rising edge
// where lu_valid & lu_ready are both high. lu_ready reflects only the
// registered FIFO count, so a pop in the same cycle does not open a slot
// until the following cycle. The producer holds lu_valid, lu_rd and lu_data
// stable until the transfer happens.
//
// Ports:
//   CLK, nRST                      clock, asynchronous active-low reset
//   pipe_wen/pipe_rd/pipe_data     pipeline writeback (priority source)
//   lu_valid/lu_rd/lu_data         long-latency result, with lu_ready back
//   issue_valid/issue_rd           long-latency op dispatched (marks busy)
//   dec_rs1/dec_rs2/dec_rd         decode-stage registers, hazard_stall back
//   rf_wen/rf_rd/rf_w_data         register file write port
//   sb_err                         sticky scoreboard protocol error
// -----------------------------------------------------------------------------
module rf_writeback_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int WORD_W     = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              pipe_wen,
    input  logic [4:0]        pipe_rd,
    input  logic [WORD_W-1:0] pipe_data,
    input  logic              lu_valid,
    input  logic [4:0]        lu_rd,
    input  logic [WORD_W-1:0] lu_data,
    output logic              lu_ready,
    input  logic              issue_valid,
    input  logic [4:0]        issue_rd,
    input  logic [4:0]        dec_rs1,
    input  logic [4:0]        dec_rs2,
    input  logic [4:0]        dec_rd,
    output logic              hazard_stall,
    output logic              rf_wen,
    output logic [4:0]        rf_rd,
    output logic [WORD_W-1:0] rf_w_data,
    output logic              sb_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    // Result buffer
    logic [4:0]        fifo_rd   [FIFO_DEPTH];
    logic [WORD_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    // Scoreboard
    logic [31:0]       busy;
    logic [31:0]       busy_next;
    logic [31:0]       set_vec;
    logic [31:0]       clr_vec;

    logic              fifo_empty;
    logic [4:0]        head_rd;
    logic [WORD_W-1:0] head_data;
    logic              pipe_sel;
    logic              push;
    logic              pop;
    logic              issue_set;
    logic              err_now;

    always_comb begin
        fifo_empty = (count == '0);
        head_rd    = fifo_rd[rd_ptr];
        head_data  = fifo_data[rd_ptr];

        // A pipeline write to x0 is not a real write and must not block a pop.
        pipe_sel   = pipe_wen && (pipe_rd != 5'd0);
        pop        = !pipe_sel && !fifo_empty;

        lu_ready   = (count < FULL_COUNT);
        // x0 results complete the handshake but are dropped.
        push       = lu_valid && lu_ready && (lu_rd != 5'd0);

        issue_set  = issue_valid && (issue_rd != 5'd0);
    end

    // Write-port selection
    always_comb begin
        rf_wen    = 1'b0;
        rf_rd     = 5'd0;
        rf_w_data = '0;
        if (pipe_sel) begin
            rf_wen    = 1'b1;
            rf_rd     = pipe_rd;
            rf_w_data = pipe_data;
        end else if (pop) begin
            rf_wen    = 1'b1;
            rf_rd     = head_rd;
            rf_w_data = head_data;
        end
    end

    // Scoreboard next state: clear first, then set, so a same-cycle set wins.
    always_comb begin
        set_vec      = issue_set ? (32'd1 << issue_rd) : 32'd0;
        clr_vec      = pop ? (32'd1 << head_rd) : 32'd0;
        busy_next    = (busy & ~clr_vec) | set_vec;
        busy_next[0] = 1'b0;

        // Re-issuing to a busy register is only legal when that register is
        // being written back (and so freed) in the same cycle.
        err_now = (issue_set && busy[issue_rd] && !(pop && (head_rd == issue_rd)))
                || (pop && !busy[head_rd]);
    end

    // Registered busy bits only, so the stall drops once the data is in the file.
    always_comb begin
        hazard_stall = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd];
    end

    // Buffer storage is not reset; occupancy is tracked by count alone.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= lu_rd;
            fifo_data[wr_ptr] <= lu_data;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            busy   <= 32'd0;
            sb_err <= 1'b0;
        end else begin
            // Depth is a power of two, so pointers wrap by plain overflow.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            busy   <= busy_next;
            sb_err <= sb_err | err_now;
        end
    end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for rf_writeback_arbiter. A queue/array reference model tracks the
// buffered results, busy registers and the sticky error; every cycle the DUT
// outputs are compared with what the model says they must be. Directed
// scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_rf_writeback_arbiter;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    // Clock / reset
    logic        CLK;
    logic        nRST;

    // DUT inputs
    logic        pipe_wen;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;

    // DUT outputs
    logic        lu_ready;
    logic        hazard_stall;
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [31:0] rf_w_data;
    logic        sb_err;

    // Reference model state
    ent_t        exp_q[$];
    bit          mbusy[32];
    bit          merr;

    // Stimulus bookkeeping for the random phase
    logic [4:0]  pend_q[$];
    bit          hold;

    int          total;
    int          bad;

    rf_writeback_arbiter #(.FIFO_DEPTH(DEPTH), .WORD_W(32)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .pipe_wen     (pipe_wen),
        .pipe_rd      (pipe_rd),
        .pipe_data    (pipe_data),
        .lu_valid     (lu_valid),
        .lu_rd        (lu_rd),
        .lu_data      (lu_data),
        .lu_ready     (lu_ready),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_rd       (dec_rd),
        .hazard_stall (hazard_stall),
        .rf_wen       (rf_wen),
        .rf_rd        (rf_rd),
        .rf_w_data    (rf_w_data),
        .sb_err       (sb_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        pipe_wen    = 1'b0;
        pipe_rd     = 5'd0;
        pipe_data   = 32'd0;
        lu_valid    = 1'b0;
        lu_rd       = 5'd0;
        lu_data     = 32'd0;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        dec_rs1     = 5'd0;
        dec_rs2     = 5'd0;
        dec_rd      = 5'd0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        merr = 1'b0;
    endtask

    // Compare all outputs against the model at the falling edge.
    task automatic sample();
        bit          exp_wen;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        bit          exp_hz;
        @(negedge CLK);
        exp_wen  = 1'b0;
        exp_rd   = 5'd0;
        exp_data = 32'd0;
        if (pipe_wen && pipe_rd != 5'd0) begin
            exp_wen  = 1'b1;
            exp_rd   = pipe_rd;
            exp_data = pipe_data;
        end else if (exp_q.size() > 0) begin
            exp_wen  = 1'b1;
            exp_rd   = exp_q[0].rd;
            exp_data = exp_q[0].data;
        end
        exp_hz = (dec_rs1 != 0 && mbusy[dec_rs1]) || (dec_rs2 != 0 && mbusy[dec_rs2])
              || (dec_rd != 0 && mbusy[dec_rd]);
        chk("lu_ready",     {31'd0, lu_ready},     {31'd0, exp_q.size() < DEPTH});
        chk("rf_wen",       {31'd0, rf_wen},       {31'd0, exp_wen});
        chk("rf_rd",        {27'd0, rf_rd},        {27'd0, exp_rd});
        chk("rf_w_data",    rf_w_data,             exp_data);
        chk("hazard_stall", {31'd0, hazard_stall}, {31'd0, exp_hz});
        chk("sb_err",       {31'd0, sb_err},       {31'd0, merr});
    endtask

    // Apply the clock edge to the model, then release inputs for the next cycle.
    task automatic advance();
        bit         ready;
        bit         psel;
        bit         popd;
        ent_t       h;
        logic [4:0] popped_rd;
        @(posedge CLK);
        ready     = exp_q.size() < DEPTH;
        psel      = pipe_wen && pipe_rd != 5'd0;
        popd      = !psel && exp_q.size() > 0;
        popped_rd = 5'd0;
        if (popd) begin
            h         = exp_q.pop_front();
            popped_rd = h.rd;
            if (!mbusy[popped_rd]) merr = 1'b1;
        end
        if (issue_valid && issue_rd != 0 && mbusy[issue_rd] && !(popd && popped_rd == issue_rd))
            merr = 1'b1;
        if (popd) mbusy[popped_rd] = 1'b0;
        if (issue_valid && issue_rd != 0) mbusy[issue_rd] = 1'b1;
        if (lu_valid && ready && lu_rd != 0) exp_q.push_back('{lu_rd, lu_data});
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    initial begin
        int r;
        int idx;
        bit accepted;

        total = 0;
        bad   = 0;
        hold  = 1'b0;
        clear_inputs();
        model_reset();

        // ---------------- reset state ----------------
        nRST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_rf_wen",   {31'd0, rf_wen},       32'd0);
        chk("reset_lu_ready", {31'd0, lu_ready},     32'd1);
        chk("reset_hazard",   {31'd0, hazard_stall}, 32'd0);
        chk("reset_sb_err",   {31'd0, sb_err},       32'd0);
        nRST = 1'b1;
        cycle();

        // ---------------- single long-latency op ----------------
        issue_valid = 1'b1; issue_rd = 5'd7;
        cycle();
        clear_inputs(); dec_rs1 = 5'd7;
        sample(); chk("single_stall_c1", {31'd0, hazard_stall}, 32'd1); advance();
        cycle();
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'hDEADBEEF;
        cycle();
        lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;
        sample();
        chk("single_wen_c4",   {31'd0, rf_wen},  32'd1);
        chk("single_rd_c4",    {27'd0, rf_rd},   32'd7);
        chk("single_data_c4",  rf_w_data,        32'hDEADBEEF);
        chk("single_stall_c4", {31'd0, hazard_stall}, 32'd1);
        advance();
        sample(); chk("single_stall_c5", {31'd0, hazard_stall}, 32'd0); advance();

        // ---------------- priority ----------------
        clear_inputs();
        issue_valid = 1'b1; issue_rd = 5'd9;
        cycle();
        clear_inputs();
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h11;
        pipe_wen = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h22;
        sample(); chk("prio_rd_1", {27'd0, rf_rd}, 32'd3); chk("prio_data_1", rf_w_data, 32'h22); advance();
        lu_valid = 1'b0; lu_rd = 5'd0; dec_rs1 = 5'd9;
        sample(); chk("prio_rd_2", {27'd0, rf_rd}, 32'd3); advance();
        pipe_wen = 1'b0;
        sample();
        chk("prio_rd_3",    {27'd0, rf_rd}, 32'd9);
        chk("prio_data_3",  rf_w_data,      32'h11);
        chk("prio_stall_3", {31'd0, hazard_stall}, 32'd1);
        advance();
        sample(); chk("prio_stall_4", {31'd0, hazard_stall}, 32'd0); advance();

        // ---------------- full / backpressure ----------------
        clear_inputs();
        pipe_wen = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h33;
        for (int i = 0; i < 5; i++) begin
            issue_valid = 1'b1; issue_rd = 5'(10 + i);
            cycle();
        end
        issue_valid = 1'b0; issue_rd = 5'd0;
        for (int i = 0; i < 4; i++) begin
            lu_valid = 1'b1; lu_rd = 5'(10 + i); lu_data = 32'h100 + i;
            sample(); chk("full_ready_fill", {31'd0, lu_ready}, 32'd1); advance();
        end
        lu_valid = 1'b1; lu_rd = 5'd14; lu_data = 32'h104;
        sample(); chk("full_ready_0a", {31'd0, lu_ready}, 32'd0); chk("full_pipe_rd", {27'd0, rf_rd}, 32'd3); advance();
        sample(); chk("full_ready_0b", {31'd0, lu_ready}, 32'd0); advance();
        pipe_wen = 1'b0;
        sample(); chk("drain_rd_10", {27'd0, rf_rd}, 32'd10); chk("drain_ready_same", {31'd0, lu_ready}, 32'd0); advance();
        sample(); chk("drain_rd_11", {27'd0, rf_rd}, 32'd11); chk("drain_ready_next", {31'd0, lu_ready}, 32'd1); advance();
        lu_valid = 1'b0; lu_rd = 5'd0;
        sample(); chk("drain_rd_12", {27'd0, rf_rd}, 32'd12); chk("drain_data_12", rf_w_data, 32'h102); advance();
        sample(); chk("drain_rd_13", {27'd0, rf_rd}, 32'd13); advance();
        sample(); chk("drain_rd_14", {27'd0, rf_rd}, 32'd14); chk("drain_data_14", rf_w_data, 32'h104); advance();
        sample(); chk("drain_empty", {31'd0, rf_wen}, 32'd0); chk("drain_err", {31'd0, sb_err}, 32'd0); advance();

        // ---------------- x0 handling ----------------
        clear_inputs();
        pipe_wen = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h55;
        issue_valid = 1'b1; issue_rd = 5'd0;
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h77;
        sample(); chk("x0_wen_a", {31'd0, rf_wen}, 32'd0); advance();
        clear_inputs();
        sample();
        chk("x0_wen_b",  {31'd0, rf_wen},   32'd0);
        chk("x0_ready",  {31'd0, lu_ready}, 32'd1);
        chk("x0_err",    {31'd0, sb_err},   32'd0);
        advance();

        // ---------------- randomized legal traffic ----------------
        for (int n = 0; n < 2000; n++) begin
            pipe_wen  = ($urandom_range(0, 2) == 0);
            pipe_rd   = 5'($urandom_range(0, 31));
            pipe_data = $urandom;
            dec_rs1   = 5'($urandom_range(0, 31));
            dec_rs2   = 5'($urandom_range(0, 31));
            dec_rd    = 5'($urandom_range(0, 31));
            if (!hold) begin
                if (pend_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                    idx      = $urandom_range(0, pend_q.size() - 1);
                    lu_valid = 1'b1;
                    lu_rd    = pend_q[idx];
                    lu_data  = $urandom;
                    pend_q.delete(idx);
                end else if ($urandom_range(0, 15) == 0) begin
                    lu_valid = 1'b1; lu_rd = 5'd0; lu_data = $urandom;
                end else begin
                    lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;
                end
            end
            issue_valid = 1'b0; issue_rd = 5'd0;
            if ($urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, 31);
                if (r == 0) begin
                    issue_valid = 1'b1;
                end else if (!mbusy[r]) begin
                    issue_valid = 1'b1; issue_rd = 5'(r);
                    pend_q.push_back(5'(r));
                end
            end
            accepted = lu_valid && (exp_q.size() < DEPTH);
            hold     = lu_valid && !accepted;
            cycle();
        end
        // Drain: return every outstanding result with the pipeline idle.
        for (int n = 0; n < 200; n++) begin
            clear_inputs();
            if (hold) begin
                lu_valid = 1'b1; lu_rd = lu_rd; 
            end
            if (!hold && pend_q.size() > 0) begin
                lu_valid = 1'b1; lu_rd = pend_q.pop_front(); lu_data = $urandom;
            end
            accepted = lu_valid && (exp_q.size() < DEPTH);
            hold     = lu_valid && !accepted;
            cycle();
            if (hold) begin
                lu_valid = 1'b1;
            end
        end
        clear_inputs();
        sample(); chk("random_no_err", {31'd0, sb_err}, 32'd0); chk("random_drained", {31'd0, rf_wen}, 32'd0); advance();

        // ---------------- protocol error ----------------
        issue_valid = 1'b1; issue_rd = 5'd4;
        cycle();
        sample(); chk("err_before", {31'd0, sb_err}, 32'd0); advance();
        clear_inputs();
        sample(); chk("err_set", {31'd0, sb_err}, 32'd1); advance();
        repeat (3) cycle();
        sample(); chk("err_sticky", {31'd0, sb_err}, 32'd1); advance();

        // ---------------- reset mid-operation ----------------
        issue_valid = 1'b1; issue_rd = 5'd5; cycle();
        issue_rd = 5'd6; cycle();
        clear_inputs();
        pipe_wen = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h1;
        lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 32'hA5; cycle();
        lu_rd = 5'd6; lu_data = 32'hA6; cycle();
        clear_inputs(); dec_rs1 = 5'd5;
        nRST = 1'b0;
        #1;
        chk("arst_rf_wen",   {31'd0, rf_wen},       32'd0);
        chk("arst_lu_ready", {31'd0, lu_ready},     32'd1);
        chk("arst_hazard",   {31'd0, hazard_stall}, 32'd0);
        chk("arst_sb_err",   {31'd0, sb_err},       32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample(); chk("post_reset_no_write", {31'd0, rf_wen}, 32'd0); advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
